if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage. Owns the PC register, drives the instruction-memory address, and feeds
//  the IF/ID pipeline register (pc, instr, valid, pred_taken). Next-PC selection priority:
//  EX-stage redirect > hazard stall > BTB prediction > sequential PC+4.
//  The direct-mapped BTB with 2-bit counters is trained from EX-resolved branch/jump outcomes.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset; bits[1:0] must be 0
//  BTB_ENTRIES  16             BTB depth; power of 2, >=2; IDX_W = log2(BTB_ENTRIES)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_reset        in   1   synchronous, active-low reset
//  i_stall        in   1   hazard unit: hold PC (IF/ID also holds)
//  i_redirect     in   1   EX mispredict/jump: load i_redirect_pc
//  i_redirect_pc  in   32  redirect target; bits[1:0] forced to 0
//  i_upd_en       in   1   EX: resolved control-flow instr, train BTB
//  i_upd_pc       in   32  PC of the resolved instruction
//  i_upd_taken    in   1   resolved direction
//  i_upd_target   in   32  resolved taken target
//  o_imem_addr    out  32  instruction-memory address (= pc_q), combinational read
//  i_imem_rdata   in   32  instruction word at o_imem_addr, same cycle
//  o_pc           out  32  PC of the fetched instruction (= pc_q)
//  o_instr        out  32  = i_imem_rdata
//  o_valid        out  1   fetched instruction is valid
//  o_pred_taken   out  1   BTB hit with counter[1]=1
// BEHAVIOUR
//  - Reset (i_reset=0 at a rising edge): pc_q<=RESET_PC; all BTB valid bits cleared; counters<=2'b01.
//    While i_reset=0: o_valid=0, o_pred_taken=0; o_pc/o_imem_addr=pc_q; i_upd_en ignored.
//  - o_valid = i_reset & ~i_redirect (a redirect cycle is wrong-path). Zero-latency: the fetch is
//    combinational; IF/ID captures it at the next edge.
//  - Next PC (every edge): i_redirect ? {i_redirect_pc[31:2],2'b0} : i_stall ? pc_q
//    : o_pred_taken ? btb_target[idx] : pc_q+4. Redirect overrides stall in the same cycle.
//  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000; no other handling.
//  - Lookup: idx = pc_q[IDX_W+1:2], tag = pc_q[31:IDX_W+2]. hit = valid[idx] & tag match.
//    o_pred_taken = hit & ctr[idx][1] & i_reset.
//  - Update (at edge when i_upd_en & i_reset), using i_upd_pc's idx and tag:
//    * hit: ctr saturating +1 if taken, else -1 (clamp 2'b00 / 2'b11); target<=i_upd_target if taken.
//    * miss & taken: allocate/overwrite: valid=1, tag, target, ctr=2'b10.
//    * miss & not taken: no change.
//  - Same-cycle update and lookup at the same index: lookup uses pre-edge contents (no bypass).
//  - Update is independent of i_stall/i_redirect; an update in a redirect cycle is still applied.
//  - Reset mid-operation: pending update dropped; BTB fully invalidated; fetch restarts at RESET_PC.
//  - Aliasing: a different tag at the same idx is a miss; allocation evicts the old entry.
// CONFIGURATION
//  FETCH_BTB_EN defined: BTB and counters built as above.
//  FETCH_BTB_EN undefined: no BTB storage; o_pred_taken tied 0; next PC = redirect > stall > pc_q+4;
//    i_upd_* inputs unused.
// TESTING
//  1. i_reset=0 for 2 cycles, then 1, no stall -> o_valid=0 during reset; o_pc 0x0,0x4,0x8, o_valid=1.
//  2. i_stall=1 for 3 cycles at o_pc=0x8 -> o_pc stays 0x8, o_valid=1; next after release 0xC.
//  3. i_redirect=1, i_redirect_pc=0x103, i_stall=1 same cycle -> o_valid=0; next o_pc=0x100.
//  4. Upd pc=0x10 taken tgt=0x40, then fetch 0x10 -> o_pred_taken=1; next o_pc=0x40 (needs _EN).
//  5. Then 1 not-taken upd pc=0x10 (ctr 10->01) -> fetch 0x10 gives pred_taken=0, next 0x14;
//     3 taken upds -> ctr saturates at 11; 4th taken upd leaves ctr at 11.
//  6. BTB_ENTRIES=16: entry for 0x10 present, fetch 0x50 (same idx, tag differs) -> pred_taken=0;
//     build without FETCH_BTB_EN, repeat test 4 -> pred_taken=0, o_pc 0x10 -> 0x14.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage.
// Holds the PC register, drives the instruction-memory address and presents
// pc/instr/valid/pred_taken to the IF/ID register.
// Next-PC priority: redirect > stall > BTB prediction > pc+4.
// Optional macro FETCH_BTB_EN builds the direct-mapped BTB with 2-bit
// counters. Without it, o_pred_taken is tied low and the i_upd_* inputs are unused.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_upd_en,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_pred_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pred_target;
    logic        pred_taken;

    assign o_imem_addr  = pc_q;
    assign o_pc         = pc_q;
    assign o_instr      = i_imem_rdata;
    assign o_valid      = i_reset & ~i_redirect;
    assign o_pred_taken = pred_taken;

`ifdef FETCH_BTB_EN
    logic [BTB_ENTRIES-1:0]      btb_valid;
    logic [BTB_ENTRIES-1:0][1:0] btb_ctr;
    logic [TAG_W-1:0]            btb_tag    [BTB_ENTRIES];
    logic [31:0]                 btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr;

    assign look_idx = pc_q[IDX_W+1:2];
    assign look_tag = pc_q[31:IDX_W+2];
    assign look_hit = btb_valid[look_idx] & (btb_tag[look_idx] == look_tag);
    assign upd_idx  = i_upd_pc[IDX_W+1:2];
    assign upd_tag  = i_upd_pc[31:IDX_W+2];
    assign upd_hit  = btb_valid[upd_idx] & (btb_tag[upd_idx] == upd_tag);
    assign upd_ctr  = btb_ctr[upd_idx];

    // Lookup against the pre-edge BTB contents (no bypass from a same-cycle update).
    always_comb begin
        pred_taken  = look_hit & btb_ctr[look_idx][1] & i_reset;
        pred_target = btb_target[look_idx];
    end

    // Valid bits and counters: cleared on reset, trained by EX-resolved outcomes.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            btb_valid <= '0;
            btb_ctr   <= {BTB_ENTRIES{2'b01}};
        end else if (i_upd_en) begin
            if (upd_hit) begin
                if (i_upd_taken) begin
                    btb_ctr[upd_idx] <= (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
                end else begin
                    btb_ctr[upd_idx] <= (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
                end
            end else if (i_upd_taken) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target storage: no reset needed since valid bits gate every use.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_upd_en && i_upd_taken) begin
            btb_target[upd_idx] <= i_upd_target;
            if (!upd_hit) begin
                btb_tag[upd_idx] <= upd_tag;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_redirect_pc[1:0], i_upd_pc[1:0]};
`else
    // No predictor: never predict taken.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
    end

    logic unused_bits;
    assign unused_bits = ^{i_redirect_pc[1:0], i_upd_en, i_upd_pc, i_upd_taken, i_upd_target};
`endif

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (i_redirect) begin
            pc_next = {i_redirect_pc[31:2], 2'b00};
        end else if (i_stall) begin
            pc_next = pc_q;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    // PC register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (default parameters).
// Predictor-dependent expectations follow FETCH_BTB_EN.
module tb_if_fetch_stage;

`ifdef FETCH_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        pred_taken;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content derived from its address.
    assign imem_rdata = imem_addr ^ KEY;

    if_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_upd_en      (upd_en),
        .i_upd_pc      (upd_pc),
        .i_upd_taken   (upd_taken),
        .i_upd_target  (upd_target),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .o_pc          (pc),
        .o_instr       (instr),
        .o_valid       (valid),
        .o_pred_taken  (pred_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] epc,
                                input logic evalid, input logic epred);
        chk({tag, ".pc"},    pc,        epc);
        chk({tag, ".addr"},  imem_addr, epc);
        chk({tag, ".instr"}, instr,     epc ^ KEY);
        chk({tag, ".valid"}, {31'b0, valid},      {31'b0, evalid});
        chk({tag, ".pred"},  {31'b0, pred_taken}, {31'b0, epred});
    endtask

    // Apply one cycle of inputs away from the rising edge, then settle.
    task automatic drive(input logic rst, input logic stl, input logic rd,
                         input logic [31:0] rpc, input logic ue,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        @(negedge clk);
        reset       = rst;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        upd_en      = ue;
        upd_pc      = upc;
        upd_taken   = ut;
        upd_target  = utgt;
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst1.valid", {31'b0, valid},      32'd0);
        chk("rst1.pred",  {31'b0, pred_taken}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_fetch("rst2", 32'h0, 0, 0);

        // Sequential fetch
        drive(1, 0, 0, 0, 0, 0, 0, 0);  expect_fetch("seq0", 32'h0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);  expect_fetch("seq4", 32'h4, 1, 0);

        // Stall holds the PC
        drive(1, 1, 0, 0, 0, 0, 0, 0);  expect_fetch("stall1", 32'h8, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);  expect_fetch("stall2", 32'h8, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);  expect_fetch("stall3", 32'h8, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);  expect_fetch("unstall", 32'h8, 1, 0);

        // Redirect overrides stall, low target bits dropped
        drive(1, 1, 1, 32'h103, 0, 0, 0, 0);  expect_fetch("redir", 32'hC, 0, 0);
        // Train: 0x10 taken -> 0x40 (allocate, ctr 10)
        drive(1, 0, 0, 0, 1, 32'h10, 1, 32'h40);  expect_fetch("redir_tgt", 32'h100, 1, 0);
        drive(1, 0, 1, 32'h10, 0, 0, 0, 0);        expect_fetch("to10a", 32'h104, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);             expect_fetch("pred10a", 32'h10, 1, BTB);

        // Not-taken update in a redirect cycle: ctr 10 -> 01
        drive(1, 0, 1, 32'h10, 1, 32'h10, 0, 0);
        expect_fetch("after10a", BTB ? 32'h40 : 32'h14, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);             expect_fetch("pred10b", 32'h10, 1, 0);

        // Four taken updates with new target: 01->10->11->11->11
        drive(1, 0, 0, 0, 1, 32'h10, 1, 32'h80);  expect_fetch("tk1", 32'h14, 1, 0);
        drive(1, 0, 0, 0, 1, 32'h10, 1, 32'h80);  expect_fetch("tk2", 32'h18, 1, 0);
        drive(1, 0, 0, 0, 1, 32'h10, 1, 32'h80);  expect_fetch("tk3", 32'h1C, 1, 0);
        drive(1, 0, 0, 0, 1, 32'h10, 1, 32'h80);  expect_fetch("tk4", 32'h20, 1, 0);
        // One not-taken: saturated 11 -> 10, still predicts taken
        drive(1, 0, 1, 32'h10, 1, 32'h10, 0, 0);  expect_fetch("nt5", 32'h24, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);            expect_fetch("pred10c", 32'h10, 1, BTB);

        // Alias 0x50 (same index, other tag) misses; allocate it with same-cycle lookup
        drive(1, 0, 1, 32'h50, 0, 0, 0, 0);
        expect_fetch("after10c", BTB ? 32'h80 : 32'h14, 0, 0);
        drive(1, 0, 0, 0, 1, 32'h50, 1, 32'h200);  expect_fetch("alias50", 32'h50, 1, 0);
        drive(1, 0, 1, 32'h10, 0, 0, 0, 0);         expect_fetch("seq54", 32'h54, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              expect_fetch("evict10", 32'h10, 1, 0);
        drive(1, 0, 1, 32'h50, 0, 0, 0, 0);         expect_fetch("seq14", 32'h14, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              expect_fetch("pred50", 32'h50, 1, BTB);

        // Mid-run reset with a pending update: dropped, BTB invalidated
        drive(0, 0, 0, 0, 1, 32'h50, 0, 0);
        expect_fetch("midrst", BTB ? 32'h200 : 32'h54, 0, 0);
        drive(1, 0, 1, 32'h50, 0, 0, 0, 0);         expect_fetch("restart", 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              expect_fetch("inval50", 32'h50, 1, 0);

        // PC wraps modulo 2^32
        drive(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);  expect_fetch("towrap", 32'h54, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              expect_fetch("top", 32'hFFFF_FFFC, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              expect_fetch("wrap", 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
